tft_spi_rx: RTL and testbench

Receive-side counterpart of the TFT SPI write link: a write-only, mode-0-style serial stream (MSB first, chip select active low, D/C line) is oversampled on the system clock, deserialised, and pushed with its D/C flag into a small first-word-fall-through FIFO. It sits at the panel/emulator end of the link and in loop-back benches, and feeds a command/pixel decoder through a pop handshake. Framing and overflow errors are flagged sticky.

---
 rtl/tft_spi_rx_if.sv | 28 ++
 rtl/tft_spi_rx.sv | 105 ++++++++++
 tb/tb_tft_spi_rx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_spi_rx_if.sv
// Bundle between the SPI receive FIFO and its two neighbours: the serial link
// on the way in, and the command/pixel decoder popping bytes on the way out.
interface tft_spi_rx_if;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_dc;
    // Pop handshake: rd_data/rd_dc are valid whenever empty=0; an entry is
    // consumed on the clk edge that sees rd_en=1 with empty=0, else rd_en is ignored.
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_dc;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       frame_err;

    modport master (
        output spi_clk, spi_cs, spi_mosi, spi_dc, rd_en, clr_err,
        input  rd_data, rd_dc, empty, full, overflow, frame_err
    );

    modport slave (
        input  spi_clk, spi_cs, spi_mosi, spi_dc, rd_en, clr_err,
        output rd_data, rd_dc, empty, full, overflow, frame_err
    );
endinterface

// File: rtl/tft_spi_rx.sv
// Oversampling receiver for the write-only TFT SPI link: synchronise, shift in
// MSB-first bytes, and queue {dc, byte} in a first-word-fall-through FIFO.
module tft_spi_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    tft_spi_rx_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        frame_err_q, frame_err_d;

    logic sclk_s, cs_s, mosi_s, dc_s;
    logic sclk_rise, cs_rise, byte_done;
    logic empty, full, pop, push, drop;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign byte_done = sclk_rise & ~cs_s & (bit_cnt_q == 3'd7);

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = bus.rd_en & ~empty;
    assign push  = byte_done & (~full | pop);
    assign drop  = byte_done & full & ~pop;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = (overflow_q & ~bus.clr_err) | drop;
        frame_err_d = (frame_err_q & ~bus.clr_err) | (cs_rise & (bit_cnt_q != 3'd0));
        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'h000;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.spi_dc};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            // The 8th bit goes straight from the synchroniser into the FIFO word.
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= {dc_s, shift_q[6:0], mosi_s};
        end
    end

    assign bus.rd_data   = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign bus.rd_dc     = mem_q[rd_ptr_q[AW-1:0]][8];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_tft_spi_rx.sv
// Bench for tft_spi_rx: SPI driver tasks feed a FIFO-level reference model;
// a negedge monitor checks every pop against the expected queue.
module tb_tft_spi_rx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tft_spi_rx_if bus ();

    tft_spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         exp_ovf = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         rd_rand = 1'b0;
    bit         rd_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sole driver of rd_en: random pops or a directed request.
    initial begin
        bus.rd_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rd_en = rd_rand ? ($urandom_range(0, 1) == 1) : rd_force;
        end
    end

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected none", {bus.rd_dc, bus.rd_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_data", {24'h0, bus.rd_data}, {24'h0, mon_e[7:0]});
                check("pop_dc", {31'h0, bus.rd_dc}, {31'h0, mon_e[8]});
            end
        end
    end

    // Reference model: a completed byte is queued if room exists, else dropped.
    task automatic model_byte(input logic [7:0] b, input logic dc);
        if (exp_q.size() < DEPTH) exp_q.push_back({dc, b});
        else exp_ovf = 1'b1;
    endtask

    task automatic spi_send(input logic [7:0] b, input logic dc, input int nbits,
                            input bit pop_at_write, input bit chk_lat);
        bus.spi_dc = dc;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = b[7-i];
            cyc($urandom_range(2, 3));
            bus.spi_clk = 1'b1;
            if (i == 7) begin
                cyc(2);
                if (chk_lat) check("lat_before", {31'h0, bus.empty}, 32'd1);
                if (pop_at_write) rd_force = 1'b1;
                cyc(1);
                rd_force = 1'b0;
                model_byte(b, dc);
                if (chk_lat) check("lat_after", {31'h0, bus.empty}, 32'd0);
            end else begin
                cyc($urandom_range(2, 3));
            end
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        cyc(3);
    endtask

    task automatic cs_high();
        cyc(2);
        bus.spi_cs = 1'b1;
        cyc(4);
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        cyc(1);
        bus.clr_err = 1'b0;
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        cyc(1);
    endtask

    task automatic check_err(input string tag);
        check({tag, "_overflow"}, {31'h0, bus.overflow}, {31'h0, exp_ovf});
        check({tag, "_frame_err"}, {31'h0, bus.frame_err}, {31'h0, exp_ferr});
    endtask

    task automatic drain();
        rd_rand = 1'b1;
        for (int k = 0; k < 2000 && (exp_q.size() != 0 || !bus.empty); k++) cyc(1);
        rd_rand = 1'b0;
        cyc(2);
        check("drain_model", exp_q.size(), 32'd0);
        check("drain_empty", {31'h0, bus.empty}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, {31'h0, bus.empty}, 32'd1);
        check({tag, "_full"}, {31'h0, bus.full}, 32'd0);
        check({tag, "_overflow"}, {31'h0, bus.overflow}, 32'd0);
        check({tag, "_frame_err"}, {31'h0, bus.frame_err}, 32'd0);
        check({tag, "_rd_data"}, {24'h0, bus.rd_data}, 32'd0);
        check({tag, "_rd_dc"}, {31'h0, bus.rd_dc}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       d;
        int         nb;
        bus.spi_clk  = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.spi_dc   = 1'b0;
        bus.clr_err  = 1'b0;

        rst = 1'b0;
        cyc(3);
        check_reset("reset");
        rst = 1'b1;
        cyc(2);

        // Single byte with latency check and a directed pop
        cs_low();
        spi_send(8'hA5, 1'b1, 8, 1'b0, 1'b1);
        cs_high();
        check("t1_head_data", {24'h0, bus.rd_data}, 32'hA5);
        check("t1_head_dc", {31'h0, bus.rd_dc}, 32'd1);
        rd_force = 1'b1;
        cyc(1);
        rd_force = 1'b0;
        cyc(2);
        check("t1_empty_after_pop", {31'h0, bus.empty}, 32'd1);
        check_err("t1");

        // Back-to-back bytes in one frame
        cs_low();
        spi_send(8'h2C, 1'b0, 8, 1'b0, 1'b0);
        spi_send(8'h12, 1'b1, 8, 1'b0, 1'b0);
        spi_send(8'h34, 1'b1, 8, 1'b0, 1'b0);
        cs_high();
        drain();
        check_err("t2");

        // Overflow: six bytes, no reads
        cs_low();
        for (int i = 0; i < 4; i++) spi_send(8'($urandom), 1'($urandom), 8, 1'b0, 1'b0);
        check("t3_full4", {31'h0, bus.full}, 32'd1);
        check("t3_no_ovf_yet", {31'h0, bus.overflow}, 32'd0);
        for (int i = 0; i < 2; i++) spi_send(8'($urandom), 1'($urandom), 8, 1'b0, 1'b0);
        cs_high();
        check("t3_full6", {31'h0, bus.full}, 32'd1);
        check_err("t3");
        drain();
        pulse_clr();
        check_err("t3_clr");

        // Frame error after 5 bits, then a clean byte
        cs_low();
        spi_send(8'($urandom), 1'b1, 5, 1'b0, 1'b0);
        cyc(2);
        bus.spi_cs = 1'b1;
        cyc(2);
        check("t4_ferr_early", {31'h0, bus.frame_err}, 32'd0);
        cyc(1);
        check("t4_ferr_set", {31'h0, bus.frame_err}, 32'd1);
        exp_ferr = 1'b1;
        cyc(3);
        cs_low();
        spi_send(8'h3C, 1'b0, 8, 1'b0, 1'b0);
        cs_high();
        drain();
        check_err("t4");
        pulse_clr();
        check_err("t4_clr");

        // Pop in the same cycle a byte lands in a full FIFO
        cs_low();
        for (int i = 0; i < 4; i++) spi_send(8'($urandom), 1'($urandom), 8, 1'b0, 1'b0);
        spi_send(8'hC3, 1'b1, 8, 1'b1, 1'b0);
        cs_high();
        check("t5_full", {31'h0, bus.full}, 32'd1);
        check_err("t5");
        drain();

        // Reset mid-byte with an entry queued
        cs_low();
        spi_send(8'h55, 1'b1, 8, 1'b0, 1'b0);
        spi_send(8'($urandom), 1'b1, 4, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2);
        check_reset("t6_in_reset");
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        rst = 1'b1;
        cyc(2);
        cs_high();
        cs_low();
        spi_send(8'h81, 1'b1, 8, 1'b0, 1'b0);
        cs_high();
        check("t6_head", {24'h0, bus.rd_data}, 32'h81);
        check_err("t6");
        drain();

        // Random frames with a random reader
        rd_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            cs_low();
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                d = 1'($urandom);
                spi_send(b, d, 8, 1'b0, 1'b0);
            end
            cs_high();
        end
        drain();
        check_err("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
